// File: rtl/result_sat_fifo.sv
// result_sat_fifo: converts Q7.25 evaluator results to saturated Q2.14 samples
// and buffers them in a show-ahead circular FIFO. Each entry holds {sat, data}.
// A sticky saturating counter records how many saturated samples were accepted.
module result_sat_fifo #(
  parameter int WIDTHIN  = 32,
  parameter int WIDTHOUT = 16,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTHIN-1:0]       i_y,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTHOUT-1:0]      o_data,
  output logic                     o_sat,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic [7:0]               o_sat_count
);

  // Q7.25 -> Q2.14 drops 11 fractional bits; the dropped MSB drives rounding.
  localparam int FRAC_DROP = 11;
  localparam int TW        = WIDTHIN - FRAC_DROP + 1;
  localparam int EW        = WIDTHOUT + 1;
  localparam int AW        = $clog2(DEPTH);
  localparam int LW        = AW + 1;

  localparam logic [AW-1:0] PTR_ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_ONE   = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
  localparam logic [TW-1:0] T_MAX     = {{(TW-WIDTHOUT){1'b0}}, {WIDTHOUT{1'b1}}};
  localparam logic [7:0]    CNT_MAX   = 8'hFF;
  localparam logic [7:0]    CNT_ONE   = 8'h01;

  // Round-half-up and saturate one sample; result is {sat, data}.
  function automatic logic [EW-1:0] convert_sample(input logic [WIDTHIN-1:0] y);
    logic [TW-1:0] t;
    t = {1'b0, y[WIDTHIN-1:FRAC_DROP]} + {{(TW-1){1'b0}}, y[FRAC_DROP-1]};
    if (t > T_MAX) begin
      convert_sample = {1'b1, {WIDTHOUT{1'b1}}};
    end else begin
      convert_sample = {1'b0, t[WIDTHOUT-1:0]};
    end
  endfunction

  logic [EW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [7:0]      sat_cnt_q, sat_cnt_d;
  logic [EW-1:0]   entry_s;
  logic [EW-1:0]   head_s;
  logic            push_s;
  logic            pop_s;
  logic            ready_s;
  logic            valid_s;

  // Handshake flags come from registered occupancy only.
  always_comb begin
    ready_s = (level_q != LVL_FULL);
    valid_s = (level_q != LVL_ZERO);
    push_s  = i_valid & ready_s;
    pop_s   = valid_s & i_ready;
    entry_s = convert_sample(i_y);
    head_s  = mem_q[rd_ptr_q];
  end

  // Next-state for pointers, occupancy and saturation counter.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    sat_cnt_d = sat_cnt_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (push_s && entry_s[EW-1] && (sat_cnt_q != CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + CNT_ONE;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Control state registers, cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      level_q   <= LVL_ZERO;
      sat_cnt_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sat_cnt_q <= sat_cnt_d;
    end
  end

  // Entry storage; cleared on reset so no stale sample can ever reach the head.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {EW{1'b0}};
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  // Show-ahead head presentation, forced to zero while empty.
  always_comb begin
    o_data = {WIDTHOUT{1'b0}};
    o_sat  = 1'b0;
    if (valid_s) begin
      o_data = head_s[WIDTHOUT-1:0];
      o_sat  = head_s[EW-1];
    end else begin
      o_data = {WIDTHOUT{1'b0}};
      o_sat  = 1'b0;
    end
  end

  assign o_ready     = ready_s;
  assign o_valid     = valid_s;
  assign o_level     = level_q;
  assign o_sat_count = sat_cnt_q;

endmodule

// File: tb/tb_result_sat_fifo.sv
// Self-checking bench for result_sat_fifo: directed scenarios plus random
// traffic, compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_result_sat_fifo;

  localparam int DEPTH = 8;

  logic        clk;
  logic        reset;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_y;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_data;
  logic        o_sat;
  logic [3:0]  o_level;
  logic [7:0]  o_sat_count;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [16:0] model_q[$];
  int          model_cnt = 0;

  result_sat_fifo #(.WIDTHIN(32), .WIDTHOUT(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_y(i_y), .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_sat(o_sat), .o_level(o_level), .o_sat_count(o_sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference conversion: drop 11 fractional bits with round-half-up, clamp.
  function automatic logic [16:0] ref_convert(input logic [31:0] y);
    longint t;
    t = longint'(y / 2048) + longint'((y / 1024) % 2);
    if (t > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(t)};
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".level"}, 32'(o_level), 32'(model_q.size()));
    chk({tag, ".ready"}, 32'(o_ready), 32'(model_q.size() != DEPTH));
    chk({tag, ".valid"}, 32'(o_valid), 32'(model_q.size() != 0));
    chk({tag, ".satcnt"}, 32'(o_sat_count), 32'(model_cnt));
    if (model_q.size() != 0) begin
      chk({tag, ".data"}, 32'(o_data), 32'(model_q[0][15:0]));
      chk({tag, ".sat"}, 32'(o_sat), 32'(model_q[0][16]));
    end
  endtask

  // One clock: drive at negedge, update model at posedge, check at next negedge.
  task automatic cycle(input logic v, input logic [31:0] y, input logic r, input string tag);
    bit do_push, do_pop;
    logic [16:0] e;
    i_valid = v;
    i_y     = y;
    i_ready = r;
    @(posedge clk);
    do_push = v && (model_q.size() < DEPTH);
    do_pop  = r && (model_q.size() > 0);
    e = ref_convert(y);
    if (do_pop) void'(model_q.pop_front());
    if (do_push) begin
      model_q.push_back(e);
      if (e[16] && model_cnt < 255) model_cnt++;
    end
    @(negedge clk);
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse in the middle of a low clock phase.
  task automatic pulse_reset(input string tag);
    #2;
    reset = 1'b1;
    #1;
    chk({tag, ".rst_valid"}, 32'(o_valid), 32'd0);
    chk({tag, ".rst_level"}, 32'(o_level), 32'd0);
    chk({tag, ".rst_satcnt"}, 32'(o_sat_count), 32'd0);
    chk({tag, ".rst_ready"}, 32'(o_ready), 32'd1);
    chk({tag, ".rst_data"}, 32'(o_data), 32'd0);
    chk({tag, ".rst_sat"}, 32'(o_sat), 32'd0);
    model_q.delete();
    model_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_y();
    case ($urandom_range(0, 5))
      0: return $urandom();
      1: return 32'h07FF_F000 + 32'($urandom_range(0, 32'h1FFF));
      2: return 32'($urandom_range(0, 32'h0000_1000));
      3: return $urandom() & 32'h07FF_FFFF;
      4: return 32'h0800_0000 | $urandom();
      default: return 32'h0200_0000 + 32'($urandom_range(0, 32'hFFFF));
    endcase
  endfunction

  initial begin
    reset   = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b0;
    i_y     = 32'h0;
    repeat (2) @(negedge clk);
    check_outputs("reset");
    reset = 1'b0;

    // 1.0 passes straight through as 0x4000.
    cycle(1'b1, 32'h0200_0000, 1'b0, "one");
    chk("one.data_const", 32'(o_data), 32'h4000);
    cycle(1'b0, 32'h0, 1'b1, "one_pop");

    // Rounding boundary.
    cycle(1'b1, 32'h0000_0400, 1'b0, "rnd_up");
    chk("rnd_up.data_const", 32'(o_data), 32'h0001);
    cycle(1'b0, 32'h0, 1'b1, "rnd_up_pop");
    cycle(1'b1, 32'h0000_03FF, 1'b0, "rnd_dn");
    chk("rnd_dn.data_const", 32'(o_data), 32'h0000);
    cycle(1'b0, 32'h0, 1'b1, "rnd_dn_pop");

    // Saturation boundary.
    cycle(1'b1, 32'h07FF_FC00, 1'b0, "sat1");
    cycle(1'b1, 32'h0800_0000, 1'b0, "sat2");
    chk("sat.count_const", 32'(o_sat_count), 32'd2);
    cycle(1'b1, 32'h07FF_F800, 1'b1, "nosat");
    cycle(1'b0, 32'h0, 1'b1, "sat_pop2");
    chk("nosat.data_const", 32'(o_data), 32'hFFFF);
    chk("nosat.sat_const", 32'(o_sat), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, "sat_drain");

    // Empty with i_ready high: nothing moves.
    cycle(1'b0, 32'h0, 1'b1, "empty_pop");

    // Fill to full, drop the extra, drain in order.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 32'h0010_0000 * 32'(i + 1), 1'b0, "fill");
    chk("full.ready_const", 32'(o_ready), 32'd0);
    cycle(1'b1, 32'h0123_4567, 1'b0, "drop");
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 32'h0, 1'b1, "drain");

    // Push+pop at level 3 across the pointer wrap.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) cycle(1'b1, rand_y(), 1'b0, "l3_fill");
      cycle(1'b1, rand_y(), 1'b1, "l3_both");
      chk("l3.level_const", 32'(o_level), 32'd3);
      for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1, "l3_drain");
    end

    // Reset at level 5 with four saturated samples counted.
    pulse_reset("pre5");
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'hF000_0000, 1'b0, "lvl5_sat");
    cycle(1'b1, 32'h0100_0000, 1'b0, "lvl5_ok");
    chk("lvl5.count_const", 32'(o_sat_count), 32'd4);
    pulse_reset("mid");
    // First push right after reset release.
    cycle(1'b1, 32'h0200_0000, 1'b0, "post_rst");

    // Random traffic, including enough saturation to pin the counter.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), rand_y(), 1'($urandom_range(0, 2) != 0), "rand");
    end
    chk("rand.count_pinned", 32'(o_sat_count), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
